// File: rtl/parity_checker.sv
// Even/odd parity checker with registered per-word result, sticky error flag
// and optional saturating error counter (enabled by PARITY_ERR_CNT_EN).
module parity_checker #(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_bit,
    input  logic              valid_in,
    input  logic              clear_err,
    output logic              error,
    output logic              out_valid,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic ODD_BIT = (ODD_PARITY != 0);

    logic exp_parity;
    logic mism;
    logic hit;

    assign exp_parity = (^data_in) ^ ODD_BIT;
    assign mism       = exp_parity ^ parity_bit;
    assign hit        = valid_in & mism;

    always_ff @(posedge clk) begin
        if (rst) begin
            error      <= 1'b0;
            out_valid  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            out_valid <= valid_in;
            if (valid_in) begin
                error <= mism;
            end
            // A mismatch in the clearing cycle survives the clear.
            if (hit) begin
                err_sticky <= 1'b1;
            end else if (clear_err) begin
                err_sticky <= 1'b0;
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_base = clear_err ? '0 : cnt_q;
        cnt_next = cnt_base;
        if (hit && (cnt_base != CNT_MAX)) begin
            cnt_next = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next;
        end
    end

    assign err_count = cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_checker.sv
// Directed self-checking bench for parity_checker: even, odd and narrow-counter
// instances share one stimulus stream.
module tb_parity_checker;

`ifdef PARITY_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       parity_bit;
    logic       valid_in;
    logic       clear_err;

    logic        e_error, e_ov, e_sticky;
    logic [15:0] e_cnt;
    logic        o_error, o_ov, o_sticky;
    logic [15:0] o_cnt;
    logic        s_error, s_ov, s_sticky;
    logic [1:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    parity_checker #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(16)) u_even (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_bit(parity_bit),
        .valid_in(valid_in), .clear_err(clear_err),
        .error(e_error), .out_valid(e_ov), .err_sticky(e_sticky), .err_count(e_cnt)
    );

    parity_checker #(.DATA_W(8), .ODD_PARITY(1), .CNT_W(16)) u_odd (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_bit(parity_bit),
        .valid_in(valid_in), .clear_err(clear_err),
        .error(o_error), .out_valid(o_ov), .err_sticky(o_sticky), .err_count(o_cnt)
    );

    parity_checker #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_bit(parity_bit),
        .valid_in(valid_in), .clear_err(clear_err),
        .error(s_error), .out_valid(s_ov), .err_sticky(s_sticky), .err_count(s_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one cycle of inputs, then sample 1 time unit after the edge.
    task automatic apply(input logic [7:0] d, input logic p, input logic v,
                         input logic clr, input logic r);
        data_in    = d;
        parity_bit = p;
        valid_in   = v;
        clear_err  = clr;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({e_error, e_ov, e_sticky} !== 3'b000 || e_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_even: got err=%b ov=%b sticky=%b cnt=%0d, want 0 0 0 0",
                     e_error, e_ov, e_sticky, e_cnt);
        end
        checks++;
        if ({s_error, s_ov, s_sticky} !== 3'b000 || s_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_sat: got err=%b ov=%b sticky=%b cnt=%0d, want 0 0 0 0",
                     s_error, s_ov, s_sticky, s_cnt);
        end
    endtask

    task automatic test_even();
        logic [15:0] want_cnt;
        apply(8'b10101010, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({e_error, e_ov, e_sticky} !== 3'b010 || e_cnt !== 16'd0) begin
            errors++;
            $display("FAIL even_match: got err=%b ov=%b sticky=%b cnt=%0d, want 0 1 0 0",
                     e_error, e_ov, e_sticky, e_cnt);
        end
        apply(8'b10101011, 1'b0, 1'b1, 1'b0, 1'b0);
        want_cnt = CNT_EN ? 16'd1 : 16'd0;
        checks++;
        if ({e_error, e_ov, e_sticky} !== 3'b111 || e_cnt !== want_cnt) begin
            errors++;
            $display("FAIL even_mismatch: got err=%b ov=%b sticky=%b cnt=%0d, want 1 1 1 %0d",
                     e_error, e_ov, e_sticky, e_cnt, want_cnt);
        end
        apply(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({e_error, e_ov, e_sticky} !== 3'b101 || e_cnt !== want_cnt) begin
            errors++;
            $display("FAIL even_idle_hold: got err=%b ov=%b sticky=%b cnt=%0d, want 1 0 1 %0d",
                     e_error, e_ov, e_sticky, e_cnt, want_cnt);
        end
        // Two flipped bits of 8'hAA keep even weight: undetectable.
        apply(8'b10101001, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (e_error !== 1'b0 || e_ov !== 1'b1 || e_cnt !== want_cnt) begin
            errors++;
            $display("FAIL even_double_flip: got err=%b ov=%b cnt=%0d, want 0 1 %0d",
                     e_error, e_ov, e_cnt, want_cnt);
        end
    endtask

    task automatic test_odd();
        apply(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_error !== 1'b0 || o_ov !== 1'b1) begin
            errors++;
            $display("FAIL odd_match: got err=%b ov=%b, want 0 1", o_error, o_ov);
        end
        apply(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_error !== 1'b1 || o_ov !== 1'b1 || o_sticky !== 1'b1) begin
            errors++;
            $display("FAIL odd_mismatch: got err=%b ov=%b sticky=%b, want 1 1 1",
                     o_error, o_ov, o_sticky);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d_tab [4] = '{8'h01, 8'h03, 8'h07, 8'h00};
        logic       p_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       w_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            apply(d_tab[i], p_tab[i], 1'b1, 1'b0, 1'b0);
            checks++;
            if (e_error !== w_tab[i] || e_ov !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got err=%b ov=%b, want %b 1",
                         i, e_error, e_ov, w_tab[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [1:0] want;
        apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            apply(8'b10101011, 1'b0, 1'b1, 1'b0, 1'b0);
            want = CNT_EN ? want_tab[i] : 2'd0;
            checks++;
            if (s_cnt !== want || s_sticky !== 1'b1 || s_error !== 1'b1) begin
                errors++;
                $display("FAIL sat_count[%0d]: got cnt=%0d sticky=%b err=%b, want %0d 1 1",
                         i, s_cnt, s_sticky, s_error, want);
            end
        end
        apply(8'b10101011, 1'b0, 1'b1, 1'b1, 1'b0);
        want = CNT_EN ? 2'd1 : 2'd0;
        checks++;
        if (s_cnt !== want || s_sticky !== 1'b1) begin
            errors++;
            $display("FAIL clear_with_mismatch: got cnt=%0d sticky=%b, want %0d 1",
                     s_cnt, s_sticky, want);
        end
        apply(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (s_cnt !== 2'd0 || s_sticky !== 1'b0 || s_error !== 1'b1 || s_ov !== 1'b0) begin
            errors++;
            $display("FAIL clear_alone: got cnt=%0d sticky=%b err=%b ov=%b, want 0 0 1 0",
                     s_cnt, s_sticky, s_error, s_ov);
        end
    endtask

    task automatic test_reset_midstream();
        apply(8'b10101011, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(8'b10101011, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({e_error, e_ov, e_sticky} !== 3'b000 || e_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_midstream: got err=%b ov=%b sticky=%b cnt=%0d, want 0 0 0 0",
                     e_error, e_ov, e_sticky, e_cnt);
        end
        apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (e_ov !== 1'b0 || e_error !== 1'b0 || e_sticky !== 1'b0 || s_ov !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse: got ov=%b err=%b sticky=%b sat_ov=%b, want 0 0 0 0",
                     e_ov, e_error, e_sticky, s_ov);
        end
    endtask

    initial begin
        rst        = 1'b1;
        data_in    = 8'h00;
        parity_bit = 1'b0;
        valid_in   = 1'b0;
        clear_err  = 1'b0;
        #2;
        test_reset();
        test_even();
        test_odd();
        test_back_to_back();
        test_saturation();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_checker.md
Name: parity_checker

Overview:
- Synchronous even/odd parity checker for a DATA_W-bit data word plus one received parity bit.
- Flags a per-word mismatch one cycle after a valid input.
- Keeps a sticky error flag and an optional saturating error counter for status/CSR readout.
- Sits on the receive side of a byte-oriented link, after the deserializer.

Parameters:
- DATA_W, 8, width of data_in in bits (must be ≥ 1).
- ODD_PARITY, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (XOR must be 1).
- CNT_W, 16, width of err_count (must be ≥ 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  received data word.
- parity_bit  input  1  received parity bit for data_in.
- valid_in  input  1  data_in/parity_bit are checked this cycle when high.
- clear_err  input  1  synchronous clear of err_sticky and err_count.
- error  output  1  registered mismatch result of the last checked word.
- out_valid  output  1  one-cycle pulse; error is freshly updated.
- err_sticky  output  1  set by any detected mismatch; held until clear_err or rst.
- err_count  output  CNT_W  number of detected mismatches, saturating.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values (rst high at a rising edge): error=0, out_valid=0, err_sticky=0, err_count=0. rst overrides every other input.
- Expected parity: exp = XOR-reduce(data_in) XOR ODD_PARITY.
- Mismatch: mism = exp XOR parity_bit.
  - Even mode, data 8'b10101010 (four ones): exp=0.
  - parity_bit=0 → no error; parity_bit=1 → error.
- Latency: 1 cycle. Inputs sampled at edge N with valid_in=1 produce error=mism and out_valid=1 after edge N.
- valid_in=0 at an edge: out_valid←0, error holds its previous value, no counter or flag change. data_in/parity_bit are don't-care.
- Back-to-back valid words are accepted every cycle. No backpressure; no ready signal.
- err_sticky: set to 1 on any valid cycle with mism=1.
- err_count: increments by 1 on any valid cycle with mism=1. Holds at 2^CNT_W−1 (no wrap).
- clear_err=1 at an edge: err_sticky and err_count are cleared first, then the same cycle's valid mismatch is applied.
  - Simultaneous clear_err and valid mismatch: err_sticky=1, err_count=1.
  - clear_err alone: both go to 0.
  - clear_err does not affect error or out_valid.
- Reset mid-stream: a word presented in the same cycle as rst is discarded. No out_valid follows it.
- Multi-bit errors: an even number of flipped bits is undetectable by design. No indication is produced.

Optional Feature:
- Macro PARITY_ERR_CNT_EN.
- Defined: err_count is implemented as specified above.
- Not defined: the counter register is not built. err_count is driven constant 0; err_sticky, error and out_valid are unchanged.

Test Plan:
- Even mode, data_in=8'b10101010, parity_bit=0, valid_in=1 → next cycle: error=0, out_valid=1, err_sticky=0, err_count=0.
- Even mode, data_in=8'b10101011, parity_bit=0 → error=1, out_valid=1, err_sticky=1, err_count=1. Following idle cycle: out_valid=0, error stays 1.
- ODD_PARITY=1, data_in=8'hFF, parity_bit=1 → error=0. Same data with parity_bit=0 → error=1.
- CNT_W=2, five consecutive mismatching words → err_count goes 1,2,3,3,3. Then clear_err=1 together with a mismatching word → err_count=1, err_sticky=1.
- Assert rst for one cycle during a mismatching valid word after prior errors → all outputs 0 next cycle, no out_valid pulse for that word.
- Build without PARITY_ERR_CNT_EN, three mismatches → err_count=0, err_sticky=1.
